// File: rtl/score_pkg.sv
// score_pkg -- shared types and constants for the score keeper.
//   bcd_t    : one BCD digit
//   seg_t    : active-low 7-segment pattern, bit0 = a ... bit6 = g
//   SEG_*    : decimal glyphs 0-9 and blank
//   digit_e  : digit-select encoding (value = anode index, 3 = leftmost)
//   bcd_step : next value of a packed two-digit BCD tally with wrap at a limit
package score_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;
    localparam seg_t SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        DIG_LOSS_ONES = 2'd0,
        DIG_LOSS_TENS = 2'd1,
        DIG_WIN_ONES  = 2'd2,
        DIG_WIN_TENS  = 2'd3
    } digit_e;

    // Packed {tens,ones} increment; a tally sitting at max_bcd rolls to 00.
    function automatic logic [7:0] bcd_step(input logic [7:0] cur,
                                            input logic [7:0] max_bcd);
        logic [7:0] nxt;
        if (cur == max_bcd)
            nxt = '0;
        else if (cur[3:0] == 4'd9)
            nxt = {cur[7:4] + 4'd1, 4'd0};
        else
            nxt = {cur[7:4], cur[3:0] + 4'd1};
        return nxt;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// bcd_to_seg -- combinational BCD to active-low 7-segment decoder.
//   bcd : 4-bit BCD digit in
//   seg : active-low segments out (bit0 = a); codes 10-15 give blank
module bcd_to_seg
    import score_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_keeper.sv
// score_keeper -- win/loss tally with a 4-digit multiplexed 7-segment display.
//   clk    : system clock, all state on the rising edge
//   rst    : synchronous active-high reset
//   win    : level, high while the game sits in its win state
//   lose   : level, high while the game sits in its lose state
//   clr    : synchronous tally clear (beats coincident events)
//   seg    : registered active-low segments, bit0 = a
//   an     : registered active-low anodes, an[3] leftmost
//   wins   : packed BCD win tally {tens,ones}
//   losses : packed BCD loss tally {tens,ones}
// Parameters: REFRESH_BITS (scan counter width, dwell 2^(REFRESH_BITS-2)),
//             MAX_SCORE (1..99, tally wraps to 00 after this value).
// Build option: define LEADING_ZERO_BLANK_EN to blank a zero tens digit.
module score_keeper
    import score_pkg::*;
#(
    parameter int REFRESH_BITS = 18,
    parameter int MAX_SCORE    = 99
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       win,
    input  logic       lose,
    input  logic       clr,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic [7:0] wins,
    output logic [7:0] losses
);

    localparam logic [7:0] MAX_BCD = {4'(MAX_SCORE / 10), 4'(MAX_SCORE % 10)};

    logic                    win_d;
    logic                    lose_d;
    logic                    win_ev;
    logic                    lose_ev;
    logic [REFRESH_BITS-1:0] scan_cnt;
    digit_e                  digit;
    bcd_t                    digit_val;
    logic                    digit_is_tens;
    logic [3:0]              an_next;
    seg_t                    dec_seg;
    seg_t                    seg_next;

    // The delay registers track the live inputs even during reset, so a
    // level held through reset is never seen as a rising edge; clr leaves
    // them alone for the same reason.
    always_ff @(posedge clk) begin
        win_d  <= win;
        lose_d <= lose;
    end

    assign win_ev  = win  & ~win_d;
    assign lose_ev = lose & ~lose_d;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wins   <= '0;
            losses <= '0;
        end else begin
            if (win_ev)
                wins <= bcd_step(wins, MAX_BCD);
            if (lose_ev)
                losses <= bcd_step(losses, MAX_BCD);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            scan_cnt <= '0;
        else
            scan_cnt <= scan_cnt + 1'b1;
    end

    // Counter top bits 00,01,10,11 walk the digits leftmost first (3,2,1,0).
    assign digit = digit_e'(~scan_cnt[REFRESH_BITS-1 -: 2]);

    always_comb begin
        digit_val     = losses[3:0];
        digit_is_tens = 1'b0;
        an_next       = 4'b1110;
        case (digit)
            DIG_WIN_TENS: begin
                digit_val     = wins[7:4];
                digit_is_tens = 1'b1;
                an_next       = 4'b0111;
            end
            DIG_WIN_ONES: begin
                digit_val = wins[3:0];
                an_next   = 4'b1011;
            end
            DIG_LOSS_TENS: begin
                digit_val     = losses[7:4];
                digit_is_tens = 1'b1;
                an_next       = 4'b1101;
            end
            DIG_LOSS_ONES: begin
                digit_val = losses[3:0];
                an_next   = 4'b1110;
            end
            default: begin
                digit_val = losses[3:0];
                an_next   = 4'b1110;
            end
        endcase
    end

    bcd_to_seg u_bcd_to_seg (
        .bcd (digit_val),
        .seg (dec_seg)
    );

    always_comb begin
        seg_next = dec_seg;
`ifdef LEADING_ZERO_BLANK_EN
        if (digit_is_tens && (digit_val == 4'd0))
            seg_next = SEG_BLANK;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= '1;
            seg <= SEG_BLANK;
        end else begin
            an  <= an_next;
            seg <= seg_next;
        end
    end

    // digit_is_tens only steers blanking; keep it referenced in both builds.
    logic unused_ok;
    assign unused_ok = digit_is_tens;

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper -- directed scoreboard bench for score_keeper.
// Stimulus pushes hand-computed expectations tagged with the cycle at which
// they must hold; a monitor on the falling edge pops and compares them.
module tb_score_keeper;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       win = 1'b0;
    logic       lose = 1'b0;
    logic       clr = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic [7:0] wins;
    logic [7:0] losses;

    int cyc       = 0;
    int n_cmp     = 0;
    int n_bad     = 0;
    int scan_base = 0;

    typedef struct {
        int         cyc;
        int         kind;   // 0 wins, 1 losses, 2 an, 3 seg
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mon_act;

    score_keeper #(
        .REFRESH_BITS (4),
        .MAX_SCORE    (99)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .win    (win),
        .lose   (lose),
        .clr    (clr),
        .seg    (seg),
        .an     (an),
        .wins   (wins),
        .losses (losses)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] tens_seg(input logic [3:0] v);
`ifdef LEADING_ZERO_BLANK_EN
        if (v == 4'd0) return 7'b1111111;
`endif
        return seg_of(v);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int dly, input int kind,
                             input logic [7:0] val, input string name);
        exp_t e;
        e.cyc  = cyc + dly;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: compare every expectation due at this cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                case (sb[i].kind)
                    0:       mon_act = wins;
                    1:       mon_act = losses;
                    2:       mon_act = {4'b0000, an};
                    default: mon_act = {1'b0, seg};
                endcase
                n_cmp++;
                if (sb[i].cyc < cyc) begin
                    n_bad++;
                    $display("FAIL %s: expectation for cycle %0d checked late at %0d",
                             sb[i].name, sb[i].cyc, cyc);
                end else if (mon_act !== sb[i].val) begin
                    n_bad++;
                    $display("FAIL %s: cycle %0d got %h expected %h",
                             sb[i].name, cyc, mon_act, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    // One full pass of the 4-digit scan, starting when digit 3 is shown.
    task automatic scan_check(input logic [7:0] w, input logic [7:0] l);
        int guard;
        guard = 0;
        while ((((cyc - scan_base) % 16) != 0) && (guard < 20)) begin
            tick;
            guard++;
        end
        for (int k = 0; k < 16; k++) begin
            int         d;
            logic [3:0] exp_an;
            logic [6:0] exp_seg;
            d = 3 - (k / 4);
            case (d)
                3: begin exp_an = 4'b0111; exp_seg = tens_seg(w[7:4]); end
                2: begin exp_an = 4'b1011; exp_seg = seg_of(w[3:0]);   end
                1: begin exp_an = 4'b1101; exp_seg = tens_seg(l[7:4]); end
                default: begin exp_an = 4'b1110; exp_seg = seg_of(l[3:0]); end
            endcase
            expect_at(0, 2, {4'b0000, exp_an}, $sformatf("scan_an_%h_%h_k%0d", w, l, k));
            expect_at(0, 3, {1'b0, exp_seg},   $sformatf("scan_seg_%h_%h_k%0d", w, l, k));
            tick;
        end
    endtask

    task automatic pulse_win;
        win = 1'b1;
        tick;
        win = 1'b0;
        tick;
    endtask

    task automatic pulse_lose;
        lose = 1'b1;
        tick;
        lose = 1'b0;
        tick;
    endtask

    initial begin
        logic [7:0] exp_w;
        int         v;

        // Reset held three cycles.
        rst = 1'b1;
        tick;
        expect_at(0, 0, 8'h00, "rst_wins");
        expect_at(0, 1, 8'h00, "rst_losses");
        expect_at(0, 2, 8'h0f, "rst_an");
        expect_at(0, 3, 8'h7f, "rst_seg");
        tick;
        tick;
        rst = 1'b0;
        scan_base = cyc + 1;
        expect_at(0, 2, 8'h0f, "post_rst_an_dark");
        expect_at(1, 2, 8'h07, "first_digit_an");
        expect_at(1, 3, {1'b0, tens_seg(4'd0)}, "first_digit_seg");
        tick;

        // Long level counts once, then a one-cycle pulse counts again.
        win = 1'b1;
        expect_at(1, 0, 8'h01, "level_first_edge");
        repeat (50) tick;
        expect_at(0, 0, 8'h01, "level_counted_once");
        expect_at(0, 1, 8'h00, "losses_untouched");
        win = 1'b0;
        tick;
        win = 1'b1;
        expect_at(1, 0, 8'h02, "short_pulse");
        tick;
        win = 1'b0;
        tick;

        // Simultaneous events.
        win  = 1'b1;
        lose = 1'b1;
        expect_at(1, 0, 8'h03, "simul_wins");
        expect_at(1, 1, 8'h01, "simul_losses");
        tick;
        win  = 1'b0;
        lose = 1'b0;
        tick;

        pulse_win;
        pulse_win;
        expect_at(0, 0, 8'h05, "wins_05");
        scan_check(8'h05, 8'h01);

        repeat (6) pulse_lose;
        expect_at(0, 1, 8'h07, "losses_07");
        scan_check(8'h05, 8'h07);

        // clr beats a coincident lose event and does not re-arm edge detect.
        lose = 1'b1;
        clr  = 1'b1;
        expect_at(1, 1, 8'h00, "clr_priority_losses");
        expect_at(1, 0, 8'h00, "clr_wins");
        tick;
        clr = 1'b0;
        tick;
        expect_at(0, 1, 8'h00, "clr_keeps_edge_reg");
        lose = 1'b0;
        tick;

        // Count through BCD carries and the wrap at 99.
        for (int i = 1; i <= 100; i++) begin
            v     = i % 100;
            exp_w = {4'(v / 10), 4'(v % 10)};
            win   = 1'b1;
            expect_at(1, 0, exp_w, $sformatf("count_%0d", i));
            tick;
            win = 1'b0;
            tick;
            if (i == 23 || i == 48 || i == 69 || i == 99)
                scan_check(exp_w, 8'h00);
        end

        // Reset dominates clr and events; levels held through it never count.
        pulse_win;
        pulse_lose;
        expect_at(0, 0, 8'h01, "pre_rst_wins");
        expect_at(0, 1, 8'h01, "pre_rst_losses");
        win  = 1'b1;
        lose = 1'b1;
        clr  = 1'b1;
        rst  = 1'b1;
        expect_at(1, 0, 8'h00, "rst_dominates_wins");
        expect_at(1, 1, 8'h00, "rst_dominates_losses");
        tick;
        rst = 1'b0;
        clr = 1'b0;
        scan_base = cyc + 1;
        expect_at(0, 2, 8'h0f, "rst2_an_dark");
        expect_at(1, 2, 8'h07, "rst2_scan_restart");
        tick;
        repeat (3) tick;
        expect_at(0, 0, 8'h00, "level_through_rst_wins");
        expect_at(0, 1, 8'h00, "level_through_rst_losses");
        win  = 1'b0;
        lose = 1'b0;
        tick;
        win = 1'b1;
        expect_at(1, 0, 8'h01, "post_rst_edge");
        tick;
        win = 1'b0;
        repeat (3) tick;

        if (sb.size() != 0) begin
            n_bad += sb.size();
            $display("FAIL scoreboard_drain: got %0d unchecked entries expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
